// File: rtl/power_request_ctrl_pkg.sv
// Shared power-control package: FSM encodings and default timing constants
// (the TIME_* values are also used by the power sequencer).
package power_pkg;

  typedef enum logic [2:0] {
    IDLE_DOWN = 3'd0,
    REQ_UP    = 3'd1,
    UP        = 3'd2,
    REQ_DN    = 3'd3,
    HOLDOFF   = 3'd4
  } pwr_state_t;

  localparam logic [31:0] TIME_DEBOUNCE   = 32'd50000;
  localparam logic [31:0] TIME_LONG_PRESS = 32'd4000000;
  localparam logic [31:0] TIME_UP_TIMEOUT = 32'd200000;
  localparam logic [31:0] TIME_HOLDOFF    = 32'd1000000;

endpackage

// File: rtl/power_request_ctrl_if.sv
// Request/status bundle between the request controller (slave) and its
// environment: software strobes, fault level and sequencer handshake.
interface power_request_ctrl_if;

  logic sw_power_up;
  logic sw_power_down;
  logic fault_shutdown;
  logic power_up_done;
  logic power_down_done;
  logic power_up;
  logic power_down;
  logic fault_latched;
  logic holdoff_active;

  modport master (
    output sw_power_up, sw_power_down, fault_shutdown,
    output power_up_done, power_down_done,
    input  power_up, power_down, fault_latched, holdoff_active
  );

  modport slave (
    input  sw_power_up, sw_power_down, fault_shutdown,
    input  power_up_done, power_down_done,
    output power_up, power_down, fault_latched, holdoff_active
  );

endinterface

// File: rtl/power_request_ctrl_btn.sv
// Front-panel button: 2-flop synchroniser, debounce and press-length timer.
// Emits one-cycle short_evt (release before LONG_PRESS) and long_evt.
module btn_debounce
  import power_pkg::*;
#(
  parameter logic [31:0] DEBOUNCE_CYCLES = TIME_DEBOUNCE,
  parameter logic [31:0] LONG_PRESS      = TIME_LONG_PRESS
) (
  input  logic clk,
  input  logic reset,
  input  logic pwr_btn_n,
  output logic short_evt,
  output logic long_evt
);

  logic        sync1, sync2, btn_db;
  logic [31:0] db_cnt, press_cnt;
  logic        db_flip;

  // The raw level must disagree with btn_db for DEBOUNCE_CYCLES consecutive samples.
  assign db_flip = (sync2 != btn_db) && (db_cnt == DEBOUNCE_CYCLES - 32'd1);

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1     <= 1'b1;
      sync2     <= 1'b1;
      btn_db    <= 1'b1;
      db_cnt    <= '0;
      press_cnt <= '0;
      short_evt <= 1'b0;
      long_evt  <= 1'b0;
    end else begin
      sync1     <= pwr_btn_n;
      sync2     <= sync1;
      short_evt <= 1'b0;
      long_evt  <= 1'b0;

      if (sync2 == btn_db) begin
        db_cnt <= '0;
      end else if (db_flip) begin
        db_cnt <= '0;
        btn_db <= sync2;
        if (sync2 && (press_cnt < LONG_PRESS))
          short_evt <= 1'b1;
      end else begin
        db_cnt <= db_cnt + 32'd1;
      end

      // Saturating press timer; the long event fires on the single step into saturation.
      if (!btn_db) begin
        if (press_cnt < LONG_PRESS)
          press_cnt <= press_cnt + 32'd1;
        if (press_cnt == LONG_PRESS - 32'd1)
          long_evt <= 1'b1;
      end else begin
        press_cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/power_request_ctrl.sv
// Power request controller: arbitrates button/software/fault requests and drives
// one-cycle power_up/power_down strobes to the sequencer. Optional AUTO_POWER_ON_EN
// enables a one-shot power-up after the post-reset hold-off.
module power_request_ctrl
  import power_pkg::*;
#(
  parameter logic [31:0] DEBOUNCE_CYCLES = TIME_DEBOUNCE,
  parameter logic [31:0] LONG_PRESS      = TIME_LONG_PRESS,
  parameter logic [31:0] UP_TIMEOUT      = TIME_UP_TIMEOUT,
  parameter logic [31:0] HOLDOFF_CYCLES  = TIME_HOLDOFF
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 pwr_btn_n,
  power_request_ctrl_if.slave  bus
);

`ifdef AUTO_POWER_ON_EN
  localparam pwr_state_t  RST_STATE = HOLDOFF;
  localparam logic        RST_AUTO  = 1'b1;
  localparam logic [31:0] RST_HOLD  = HOLDOFF_CYCLES;
`else
  localparam pwr_state_t  RST_STATE = IDLE_DOWN;
  localparam logic        RST_AUTO  = 1'b0;
  localparam logic [31:0] RST_HOLD  = 32'd0;
`endif

  pwr_state_t  state, state_n;
  logic [31:0] up_tmr, up_tmr_n;
  logic [31:0] hold_tmr, hold_tmr_n;
  logic        pu_q, pu_n, pd_q, pd_n;
  logic        fault_q, fault_n;
  logic        auto_pend, auto_n;
  logic        short_evt, long_evt;
  logic        up_req, dn_req;

  btn_debounce #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .LONG_PRESS      (LONG_PRESS)
  ) u_btn (
    .clk       (clk),
    .reset     (reset),
    .pwr_btn_n (pwr_btn_n),
    .short_evt (short_evt),
    .long_evt  (long_evt)
  );

  // A short press toggles: it asks for power-up everywhere except UP, where it asks for power-down.
  assign up_req = (short_evt && (state != UP)) || bus.sw_power_up;
  assign dn_req = long_evt || bus.sw_power_down || bus.fault_shutdown ||
                  (short_evt && (state == UP));

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= RST_STATE;
      up_tmr    <= '0;
      hold_tmr  <= RST_HOLD;
      pu_q      <= 1'b0;
      pd_q      <= 1'b0;
      fault_q   <= 1'b0;
      auto_pend <= RST_AUTO;
    end else begin
      state     <= state_n;
      up_tmr    <= up_tmr_n;
      hold_tmr  <= hold_tmr_n;
      pu_q      <= pu_n;
      pd_q      <= pd_n;
      fault_q   <= fault_n;
      auto_pend <= auto_n;
    end
  end

  always_comb begin
    state_n    = state;
    up_tmr_n   = up_tmr;
    hold_tmr_n = hold_tmr;
    pu_n       = 1'b0;
    pd_n       = 1'b0;
    fault_n    = fault_q || bus.fault_shutdown;
    auto_n     = auto_pend;

    unique case (state)
      IDLE_DOWN: begin
        // dn_req covers fault_shutdown, so a present fault blocks power-up here.
        if (up_req && !dn_req) begin
          state_n  = REQ_UP;
          pu_n     = 1'b1;
          up_tmr_n = '0;
          fault_n  = 1'b0;
        end
      end
      REQ_UP: begin
        if (dn_req) begin
          state_n = REQ_DN;
          pd_n    = 1'b1;
        end else if (bus.power_up_done) begin
          state_n = UP;
        end else if (up_tmr == UP_TIMEOUT - 32'd1) begin
          state_n = REQ_DN;
          pd_n    = 1'b1;
          fault_n = 1'b1;
        end else begin
          up_tmr_n = up_tmr + 32'd1;
        end
      end
      UP: begin
        // Losing power-good while up is handled as a fault shutdown.
        if (!bus.power_up_done) begin
          state_n = REQ_DN;
          pd_n    = 1'b1;
          fault_n = 1'b1;
        end else if (dn_req) begin
          state_n = REQ_DN;
          pd_n    = 1'b1;
        end
      end
      REQ_DN: begin
        if (bus.power_down_done) begin
          state_n    = HOLDOFF;
          hold_tmr_n = HOLDOFF_CYCLES;
        end
      end
      HOLDOFF: begin
        if (hold_tmr == 32'd0) begin
          auto_n = 1'b0;
          if (auto_pend && !dn_req) begin
            state_n  = REQ_UP;
            pu_n     = 1'b1;
            up_tmr_n = '0;
            fault_n  = 1'b0;
          end else begin
            state_n = IDLE_DOWN;
          end
        end else begin
          hold_tmr_n = hold_tmr - 32'd1;
        end
      end
      default: state_n = IDLE_DOWN;
    endcase
  end

  assign bus.power_up       = pu_q;
  assign bus.power_down     = pd_q;
  assign bus.fault_latched  = fault_q;
  assign bus.holdoff_active = (state == HOLDOFF);

endmodule

// File: tb/tb_power_request_ctrl.sv
// Directed bench for power_request_ctrl with shortened timing
// (DEBOUNCE=4, LONG_PRESS=20, UP_TIMEOUT=30, HOLDOFF=10).
module tb_power_request_ctrl;
  import power_pkg::*;

`ifdef AUTO_POWER_ON_EN
  localparam logic       EXP_RST_HOLD  = 1'b1;
  localparam pwr_state_t EXP_RST_STATE = HOLDOFF;
`else
  localparam logic       EXP_RST_HOLD  = 1'b0;
  localparam pwr_state_t EXP_RST_STATE = IDLE_DOWN;
`endif

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic pwr_btn_n = 1'b1;
  int   pass_cnt = 0;
  int   total = 0;

  power_request_ctrl_if bus();

  power_request_ctrl #(
    .DEBOUNCE_CYCLES (32'd4),
    .LONG_PRESS      (32'd20),
    .UP_TIMEOUT      (32'd30),
    .HOLDOFF_CYCLES  (32'd10)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .pwr_btn_n (pwr_btn_n),
    .bus       (bus)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    bus.sw_power_up = 0; bus.sw_power_down = 0; bus.fault_shutdown = 0;
    bus.power_up_done = 0; bus.power_down_done = 0;
    reset = 1;
    repeat (3) tick;
    total++; if (bus.power_up !== 1'b0) $display("FAIL rst_pu: got %b want 0", bus.power_up); else pass_cnt++;
    total++; if (bus.power_down !== 1'b0) $display("FAIL rst_pd: got %b want 0", bus.power_down); else pass_cnt++;
    total++; if (bus.fault_latched !== 1'b0) $display("FAIL rst_fault: got %b want 0", bus.fault_latched); else pass_cnt++;
    total++; if (bus.holdoff_active !== EXP_RST_HOLD) $display("FAIL rst_holdoff: got %b want %b", bus.holdoff_active, EXP_RST_HOLD); else pass_cnt++;
    total++; if (dut.state !== EXP_RST_STATE) $display("FAIL rst_state: got %0d want %0d", dut.state, EXP_RST_STATE); else pass_cnt++;
    reset = 0;
`ifdef AUTO_POWER_ON_EN
    // Discard the auto request with a fault so the later tests start from IDLE_DOWN.
    begin
      int pu = 0;
      bus.fault_shutdown = 1;
      for (int i = 0; i < 14; i++) begin tick; pu += int'(bus.power_up); end
      bus.fault_shutdown = 0;
      tick;
      total++; if (pu !== 0) $display("FAIL auto_discard_pu: got %0d pulses want 0", pu); else pass_cnt++;
      total++; if (dut.state !== IDLE_DOWN) $display("FAIL auto_discard_state: got %0d want %0d", dut.state, IDLE_DOWN); else pass_cnt++;
    end
`endif
  endtask

  task automatic test_sw_up;
    int pu_extra = 0;
    int pd_seen = 0;
    bus.sw_power_up = 1; tick; bus.sw_power_up = 0;
    total++; if (bus.power_up !== 1'b1) $display("FAIL t1_pu_pulse: got %b want 1", bus.power_up); else pass_cnt++;
    total++; if (bus.fault_latched !== 1'b0) $display("FAIL t1_fault_clear: got %b want 0", bus.fault_latched); else pass_cnt++;
    total++; if (dut.state !== REQ_UP) $display("FAIL t1_state_req_up: got %0d want %0d", dut.state, REQ_UP); else pass_cnt++;
    for (int i = 0; i < 11; i++) begin
      tick;
      pu_extra += int'(bus.power_up);
      pd_seen  += int'(bus.power_down);
    end
    bus.power_up_done = 1;
    tick;
    pd_seen += int'(bus.power_down);
    total++; if (pu_extra !== 0) $display("FAIL t1_pu_one_cycle: got %0d extra want 0", pu_extra); else pass_cnt++;
    total++; if (dut.state !== UP) $display("FAIL t1_state_up: got %0d want %0d", dut.state, UP); else pass_cnt++;
    total++; if (pd_seen !== 0) $display("FAIL t1_no_pd: got %0d want 0", pd_seen); else pass_cnt++;
  endtask

  task automatic test_button_short;
    int pd = 0;
    int pu = 0;
    int h = 1;
    pwr_btn_n = 0; repeat (8) tick; pwr_btn_n = 1;
    for (int i = 0; i < 30; i++) begin
      tick;
      pd += int'(bus.power_down);
      pu += int'(bus.power_up);
    end
    total++; if (pd !== 1) $display("FAIL t2_pd_count: got %0d want 1", pd); else pass_cnt++;
    total++; if (pu !== 0) $display("FAIL t2_no_pu: got %0d want 0", pu); else pass_cnt++;
    total++; if (dut.state !== REQ_DN) $display("FAIL t2_state_req_dn: got %0d want %0d", dut.state, REQ_DN); else pass_cnt++;
    total++; if (bus.fault_latched !== 1'b0) $display("FAIL t2_no_fault: got %b want 0", bus.fault_latched); else pass_cnt++;
    bus.power_up_done = 0; bus.power_down_done = 1; tick; bus.power_down_done = 0;
    total++; if (bus.holdoff_active !== 1'b1) $display("FAIL t2_holdoff_entry: got %b want 1", bus.holdoff_active); else pass_cnt++;
    for (int i = 0; i < 40; i++) begin
      tick;
      if (bus.holdoff_active) h++; else break;
    end
    // Timer loads 10 on entry and counts down through 0: 11 cycles in HOLDOFF.
    total++; if (h !== 11) $display("FAIL t2_holdoff_len: got %0d want 11", h); else pass_cnt++;
    total++; if (dut.state !== IDLE_DOWN) $display("FAIL t2_state_idle: got %0d want %0d", dut.state, IDLE_DOWN); else pass_cnt++;
  endtask

  task automatic test_button_glitch_long;
    int pu = 0;
    int pd = 0;
    int le = 0;
    pwr_btn_n = 0; repeat (3) tick; pwr_btn_n = 1;
    for (int i = 0; i < 15; i++) begin tick; pu += int'(bus.power_up); end
    total++; if (pu !== 0) $display("FAIL t3_glitch_no_pu: got %0d want 0", pu); else pass_cnt++;
    pu = 0;
    pwr_btn_n = 0;
    for (int i = 0; i < 25; i++) begin
      tick;
      le += int'(dut.long_evt); pu += int'(bus.power_up); pd += int'(bus.power_down);
    end
    pwr_btn_n = 1;
    for (int i = 0; i < 20; i++) begin
      tick;
      le += int'(dut.long_evt); pu += int'(bus.power_up); pd += int'(bus.power_down);
    end
    total++; if (le !== 1) $display("FAIL t3_long_evt: got %0d want 1", le); else pass_cnt++;
    total++; if (pu !== 0) $display("FAIL t3_long_no_pu: got %0d want 0", pu); else pass_cnt++;
    total++; if (pd !== 0) $display("FAIL t3_long_no_pd: got %0d want 0", pd); else pass_cnt++;
    total++; if (dut.state !== IDLE_DOWN) $display("FAIL t3_state_idle: got %0d want %0d", dut.state, IDLE_DOWN); else pass_cnt++;
  endtask

  task automatic test_up_timeout;
    int c = 0;
    bus.sw_power_up = 1; tick; bus.sw_power_up = 0;
    for (int i = 0; i < 60; i++) begin
      tick; c++;
      if (bus.power_down) break;
    end
    total++; if (c !== 30) $display("FAIL t4_timeout_cycle: got %0d want 30", c); else pass_cnt++;
    total++; if (bus.fault_latched !== 1'b1) $display("FAIL t4_fault: got %b want 1", bus.fault_latched); else pass_cnt++;
    bus.power_down_done = 1; tick; bus.power_down_done = 0;
    for (int i = 0; i < 30; i++) begin
      tick;
      if (!bus.holdoff_active) break;
    end
    total++; if (dut.state !== IDLE_DOWN) $display("FAIL t4_state_idle: got %0d want %0d", dut.state, IDLE_DOWN); else pass_cnt++;
  endtask

  task automatic test_fault_priority;
    int pu = 0;
    bus.sw_power_up = 1; tick; bus.sw_power_up = 0;
    total++; if (bus.fault_latched !== 1'b0) $display("FAIL t5_fault_cleared: got %b want 0", bus.fault_latched); else pass_cnt++;
    bus.power_up_done = 1; tick; tick;
    bus.fault_shutdown = 1; bus.sw_power_up = 1; tick;
    bus.fault_shutdown = 0; bus.sw_power_up = 0;
    total++; if (bus.power_down !== 1'b1) $display("FAIL t5_pd: got %b want 1", bus.power_down); else pass_cnt++;
    total++; if (bus.power_up !== 1'b0) $display("FAIL t5_no_pu: got %b want 0", bus.power_up); else pass_cnt++;
    total++; if (bus.fault_latched !== 1'b1) $display("FAIL t5_fault: got %b want 1", bus.fault_latched); else pass_cnt++;
    bus.power_up_done = 0; bus.power_down_done = 1; tick; bus.power_down_done = 0;
    total++; if (bus.holdoff_active !== 1'b1) $display("FAIL t5_holdoff: got %b want 1", bus.holdoff_active); else pass_cnt++;
    bus.sw_power_up = 1; tick; bus.sw_power_up = 0;
    pu += int'(bus.power_up);
    for (int i = 0; i < 20; i++) begin tick; pu += int'(bus.power_up); end
    total++; if (pu !== 0) $display("FAIL t5_holdoff_drop: got %0d pulses want 0", pu); else pass_cnt++;
    total++; if (dut.state !== IDLE_DOWN) $display("FAIL t5_state_idle: got %0d want %0d", dut.state, IDLE_DOWN); else pass_cnt++;
  endtask

  task automatic test_reset_mid;
    bus.sw_power_up = 1; tick; bus.sw_power_up = 0;
    tick;
    // Strobes that would otherwise pulse power_down and latch a fault coincide with reset.
    reset = 1; bus.sw_power_down = 1; bus.fault_shutdown = 1; tick;
    bus.sw_power_down = 0; bus.fault_shutdown = 0;
    total++; if (bus.power_down !== 1'b0) $display("FAIL t6_no_pd: got %b want 0", bus.power_down); else pass_cnt++;
    total++; if (bus.power_up !== 1'b0) $display("FAIL t6_no_pu: got %b want 0", bus.power_up); else pass_cnt++;
    total++; if (bus.fault_latched !== 1'b0) $display("FAIL t6_fault: got %b want 0", bus.fault_latched); else pass_cnt++;
    total++; if (dut.state !== EXP_RST_STATE) $display("FAIL t6_state: got %0d want %0d", dut.state, EXP_RST_STATE); else pass_cnt++;
    reset = 0;
`ifdef AUTO_POWER_ON_EN
    begin
      int c = 0;
      for (int i = 0; i < 30; i++) begin
        tick; c++;
        if (bus.power_up) break;
      end
      total++; if (c !== 11) $display("FAIL t6_auto_latency: got %0d want 11", c); else pass_cnt++;
    end
`else
    begin
      int pu = 0;
      for (int i = 0; i < 15; i++) begin tick; pu += int'(bus.power_up); end
      total++; if (pu !== 0) $display("FAIL t6_no_auto_pu: got %0d want 0", pu); else pass_cnt++;
    end
`endif
  endtask

  initial begin
    test_reset;
    test_sw_up;
    test_button_short;
    test_button_glitch_long;
    test_up_timeout;
    test_fault_priority;
    test_reset_mid;
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
